// File: rtl/bootdata_pkg.sv
// Shared definitions for the boot-data upload initiator.
//   state_t                 : sender FSM state encoding
//   DEFAULT_RESET_CYCLES    : default length of the loader reset pulse
//   DEFAULT_TIMEOUT_CYCLES  : default ack wait limit before abort
//   TIMEOUT_W / SIZE_W      : widths of the ack timer and byte counter
package bootdata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_FILL,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } state_t;

  localparam int DEFAULT_RESET_CYCLES   = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;
  localparam int TIMEOUT_W              = 24;
  localparam int SIZE_W                 = 16;

endpackage

// File: rtl/bootdata_packer.sv
// Byte-to-word packer: big-endian lane placement, lane counter and
// remaining-byte counter for one transfer.
//   clk, reset      : clock, async active-high reset
//   load, size      : start of transfer, latch byte count, clear word
//   byte_stb/data   : accepted byte
//   clear           : clear word and lane between words
//   word            : packed word, left-aligned, zero-padded
//   word_full       : the strobed byte fills lane 3
//   last            : the strobed byte is the final byte of the transfer
//   empty           : no bytes remain
module bootdata_packer
  import bootdata_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SIZE_W-1:0] size,
  input  logic              byte_stb,
  input  logic [7:0]        byte_data,
  input  logic              clear,
  output logic [31:0]       word,
  output logic              word_full,
  output logic              last,
  output logic              empty
);

  logic [1:0]        lane;
  logic [SIZE_W-1:0] remaining;

  assign word_full = byte_stb && (lane == 2'd3);
  assign last      = byte_stb && (remaining == SIZE_W'(1));
  assign empty     = (remaining == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word      <= '0;
      lane      <= '0;
      remaining <= '0;
    end else if (load) begin
      word      <= '0;
      lane      <= '0;
      remaining <= size;
    end else if (clear) begin
      word <= '0;
      lane <= '0;
    end else if (byte_stb) begin
      // Lanes fill from the top so a short final word is already left-aligned.
      case (lane)
        2'd0:    word[31:24] <= byte_data;
        2'd1:    word[23:16] <= byte_data;
        2'd2:    word[15:8]  <= byte_data;
        default: word[7:0]   <= byte_data;
      endcase
      lane      <= lane + 2'd1;
      remaining <= remaining - SIZE_W'(1);
    end
  end

endmodule

// File: rtl/bootdata_sender.sv
// Host-side boot-data upload initiator: packs a byte stream into 32-bit
// words and hands them to rom_loader with a req/ack handshake.
//   clk, reset              : clock, async active-high reset
//   start, size             : begin transfer of size bytes (ignored while busy)
//   in_data/valid/ready     : byte source handshake
//   host_bootdata/_req/_ack : word handshake toward the loader
//   host_bootdata_reset     : loader reset pulse at transfer start
//   busy, done, error       : status; error is sticky until the next start
//
// state | meaning
// IDLE  | waiting for start
// RST   | holding host_bootdata_reset for RESET_CYCLES
// FILL  | accepting bytes into the packing word
// SEND  | req high, waiting for ack or timeout
// GAP   | one req-low cycle between words
// FIN   | done pulse, back to IDLE
module bootdata_sender
  import bootdata_pkg::*;
#(
  parameter int RESET_CYCLES   = DEFAULT_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       host_bootdata,
  output logic              host_bootdata_req,
  input  logic              host_bootdata_ack,
  output logic              host_bootdata_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [7:0]           RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [7:0]           rst_cnt;
  logic [TIMEOUT_W-1:0] to_cnt;

  logic pk_load, pk_clear, byte_stb;
  logic pk_full, pk_last, pk_empty;

  assign pk_load  = (state == ST_IDLE) && start;
  assign pk_clear = (state == ST_GAP);
  assign byte_stb = (state == ST_FILL) && in_ready && in_valid;

  bootdata_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .load      (pk_load),
    .size      (size),
    .byte_stb  (byte_stb),
    .byte_data (in_data),
    .clear     (pk_clear),
    .word      (host_bootdata),
    .word_full (pk_full),
    .last      (pk_last),
    .empty     (pk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      rst_cnt             <= '0;
      to_cnt              <= '0;
      in_ready            <= 1'b0;
      host_bootdata_req   <= 1'b0;
      host_bootdata_reset <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            error               <= 1'b0;
            busy                <= 1'b1;
            host_bootdata_reset <= 1'b1;
            rst_cnt             <= RST_LAST;
            state               <= ST_RST;
          end
        end
        ST_RST: begin
          if (rst_cnt == 8'd0) begin
            host_bootdata_reset <= 1'b0;
            if (pk_empty) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_FILL;
            end
          end else begin
            rst_cnt <= rst_cnt - 8'd1;
          end
        end
        ST_FILL: begin
          // in_ready drops on the same edge that takes the closing byte.
          if (byte_stb && (pk_full || pk_last)) begin
            in_ready          <= 1'b0;
            host_bootdata_req <= 1'b1;
            to_cnt            <= '0;
            state             <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (host_bootdata_ack) begin
            host_bootdata_req <= 1'b0;
            if (pk_empty) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              state <= ST_GAP;
            end
          end else if (to_cnt == TO_LAST) begin
            error             <= 1'b1;
            host_bootdata_req <= 1'b0;
            busy              <= 1'b0;
            state             <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TIMEOUT_W'(1);
          end
        end
        ST_GAP: begin
          in_ready <= 1'b1;
          state    <= ST_FILL;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bootdata_sender.sv
// Self-checking bench for bootdata_sender with a transfer-level model.
module tb_bootdata_sender;

  localparam int RC = 16;
  localparam int TC = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] size;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic        host_bootdata_reset;
  logic        busy;
  logic        done;
  logic        error;

  always #10 clk = ~clk;

  bootdata_sender #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .size                (size),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .host_bootdata       (host_bootdata),
    .host_bootdata_req   (host_bootdata_req),
    .host_bootdata_ack   (host_bootdata_ack),
    .host_bootdata_reset (host_bootdata_reset),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer model ----------------
  logic [7:0]  src_q[$];
  logic [31:0] got_words[$];
  int m_size = 0;
  int accepted = 0, words_acked = 0;
  int req_len = 0, rst_len = 0, last_rst_len = 0, last_req_len = 0;
  int ready_cd = 0, end_kind = 0;
  bit active = 0, timed_out = 0, start_chk = 0, exp_req_next = 0, gap_chk = 0;
  bit prev_req = 0, prev_ack = 0, prev_rst = 0;

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++)
      if (4 * k + i < m_size) w = w | (32'(src_q[4 * k + i]) << (24 - 8 * i));
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      active = 0; timed_out = 0; start_chk = 0; exp_req_next = 0; gap_chk = 0;
      prev_req = 0; prev_ack = 0; prev_rst = 0;
      req_len = 0; rst_len = 0; ready_cd = 0;
    end else begin
      if (start_chk) begin
        check("start_resp", 64'({host_bootdata_reset, busy, error}), 64'(3'b110));
        start_chk = 0;
      end
      if (host_bootdata_reset) rst_len++;
      else if (prev_rst) begin
        check("rst_len", 64'(rst_len), 64'(RC));
        last_rst_len = rst_len;
        rst_len = 0;
        if (m_size == 0) check("zero_done", 64'(done), 64'(1));
        else check("fill_entry", 64'(in_ready), 64'(1));
      end
      if (exp_req_next) begin
        check("req_lat", 64'({host_bootdata_req, in_ready}), 64'(2'b10));
        exp_req_next = 0;
      end
      if (gap_chk) begin
        check("req_gap", 64'({host_bootdata_req, in_ready}), 64'(2'b00));
        gap_chk = 0;
      end
      if (ready_cd > 0) begin
        ready_cd--;
        if (ready_cd == 0) check("ready_lat", 64'(in_ready), 64'(1));
      end
      if (prev_req && !host_bootdata_req && !prev_ack) begin
        check("timeout_len", 64'(req_len), 64'(TC));
        check("timeout_flags", 64'({error, busy, done}), 64'(3'b100));
        last_req_len = req_len;
        req_len = 0;
        active = 0;
        timed_out = 1;
        end_kind = 2;
      end
      if (host_bootdata_req) begin
        req_len++;
        check("word", 64'(host_bootdata), 64'(exp_word(words_acked)));
      end
      if (done) begin
        check("done_state", 64'({active, busy}), 64'(2'b10));
        check("done_words", 64'(words_acked), 64'((m_size + 3) / 4));
        check("done_bytes", 64'(accepted), 64'(m_size));
        active = 0;
        end_kind = 1;
      end
      if (active) check("busy", 64'(busy), 64'(1));
      else check("idle_quiet", 64'({host_bootdata_req, in_ready, host_bootdata_reset}), 64'(0));
      if (!active && timed_out) check("error_sticky", 64'(error), 64'(1));
      if (in_valid && in_ready) begin
        check("overrun", 64'(accepted < m_size), 64'(1));
        accepted++;
        if (accepted % 4 == 0 || accepted == m_size) exp_req_next = 1;
      end
      if (host_bootdata_req && host_bootdata_ack) begin
        got_words.push_back(host_bootdata);
        words_acked++;
        last_req_len = req_len;
        req_len = 0;
        gap_chk = 1;
        if (words_acked * 4 < m_size) ready_cd = 2;
      end
      if (start && !active) begin
        active = 1; start_chk = 1; timed_out = 0;
        accepted = 0; words_acked = 0; end_kind = 0;
        m_size = int'(size);
        got_words.delete();
      end
      prev_req = host_bootdata_req;
      prev_ack = host_bootdata_ack;
      prev_rst = host_bootdata_reset;
    end
  end

  // ---------------- byte source ----------------
  int src_idx = 0;
  bit src_en = 0, hold_valid = 0;

  initial begin
    in_valid = 0;
    in_data  = 0;
    forever begin
      @(negedge clk);
      if (!reset && in_valid && in_ready) src_idx++;
      @(posedge clk);
      #1;
      if (src_en) begin
        in_valid = hold_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 8'($urandom);
      end else begin
        in_valid = 0;
      end
    end
  end

  // ---------------- loader ack responder ----------------
  int ack_mode = 0;   // 0 fixed delay, 1 random delay, 2 never
  int ack_fixed = 3;
  bit spur_en = 0;
  int ack_cnt = 0, ack_tgt = 3;

  initial begin
    host_bootdata_ack = 0;
    forever begin
      @(posedge clk);
      #1;
      host_bootdata_ack = 0;
      if (!reset && host_bootdata_req) begin
        if (ack_mode != 2) begin
          if (ack_cnt >= ack_tgt) begin
            host_bootdata_ack = 1;
            ack_cnt = 0;
            ack_tgt = (ack_mode == 0) ? ack_fixed : int'($urandom_range(0, 6));
          end else begin
            ack_cnt++;
          end
        end
      end else begin
        ack_cnt = 0;
        if (spur_en && $urandom_range(0, 4) == 0) host_bootdata_ack = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input int n, input bit noise, output int kind);
    bit fin = 0;
    size = 16'(n);
    src_idx = 0;
    start = 1;
    tick();
    start = 0;
    size = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if (end_kind != 0) begin
        fin = 1;
        break;
      end
      if (noise && busy && $urandom_range(0, 15) == 0) start = 1;
      tick();
      start = 0;
    end
    check("xfer_budget", 64'(fin), 64'(1));
    kind = end_kind;
    repeat (2) tick();
  endtask

  initial begin
    int kind;
    bit ok;
    reset = 1;
    start = 0;
    size  = 0;
    repeat (2) tick();
    check("reset_state", 64'({in_ready, host_bootdata_req, host_bootdata_reset, busy, done, error, host_bootdata}), 64'(0));
    reset = 0;
    src_en = 1;
    tick();

    // two full words, ack three cycles after req
    ack_mode = 0; ack_fixed = 3; ack_tgt = 3; hold_valid = 1;
    src_q.delete();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    run_xfer(8, 0, kind);
    check("t1_end", 64'(kind), 64'(1));
    check("t1_nwords", 64'(got_words.size()), 64'(2));
    check("t1_w0", 64'(got_words[0]), 64'(32'h01020304));
    check("t1_w1", 64'(got_words[1]), 64'(32'h05060708));
    check("t1_rst_len", 64'(last_rst_len), 64'(16));
    check("model_pin", 64'(exp_word(1)), 64'(32'h05060708));

    // partial last word, valid held high past the end
    src_q.delete();
    src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC);
    src_q.push_back(8'hDD); src_q.push_back(8'hEE);
    run_xfer(5, 0, kind);
    check("t2_end", 64'(kind), 64'(1));
    check("t2_nwords", 64'(got_words.size()), 64'(2));
    check("t2_w0", 64'(got_words[0]), 64'(32'hAABBCCDD));
    check("t2_w1", 64'(got_words[1]), 64'(32'hEE000000));

    // zero-length transfer
    src_q.delete();
    run_xfer(0, 0, kind);
    check("t3_end", 64'(kind), 64'(1));
    check("t3_nwords", 64'(got_words.size()), 64'(0));
    check("t3_rst_len", 64'(last_rst_len), 64'(16));

    // ack withheld: timeout
    ack_mode = 2; hold_valid = 0;
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    run_xfer(4, 0, kind);
    check("t4_end", 64'(kind), 64'(2));
    check("t4_req_len", 64'(last_req_len), 64'(32));
    check("t4_error", 64'({error, busy, done}), 64'(3'b100));

    // randomized transfers with spurious acks and start pulses while busy
    ack_mode = 1; ack_tgt = 2; spur_en = 1;
    for (int t = 0; t < 8; t++) begin
      int n;
      n = int'($urandom_range(1, 40));
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
      run_xfer(n, 1, kind);
      check("rand_end", 64'(kind), 64'(1));
      check("rand_nwords", 64'(got_words.size()), 64'((n + 3) / 4));
    end
    spur_en = 0;

    // async reset while req is high
    ack_mode = 0; ack_fixed = 5; ack_tgt = 5;
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
    size = 16'd12;
    src_idx = 0;
    start = 1;
    tick();
    start = 0;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      if (host_bootdata_req) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("t7_req_seen", 64'(ok), 64'(1));
    #2 reset = 1;
    #1 check("t7_async_reset", 64'({in_ready, host_bootdata_req, host_bootdata_reset, busy, done, error, host_bootdata}), 64'(0));
    @(negedge clk);
    #2 reset = 0;
    tick();
    src_q.delete();
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33); src_q.push_back(8'h44);
    run_xfer(4, 0, kind);
    check("t7_end", 64'(kind), 64'(1));
    check("t7_nwords", 64'(got_words.size()), 64'(1));
    check("t7_w0", 64'(got_words[0]), 64'(32'h11223344));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
